// File: rtl/lcd_sequencer_if.sv
// Transfer handshake between lcd_sequencer and the LCD enable-pulse generator.
interface lcd_sequencer_if;
  logic       oStart;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       iDone;

  modport master (output oStart, oLCD_DATA, oLCD_RS, oLCD_RW, input iDone);
  modport slave  (input oStart, oLCD_DATA, oLCD_RS, oLCD_RW, output iDone);
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780-style init + two-line refresh sequencer over a 32-byte character buffer.
// Optional LCD_AUTO_REFRESH_EN: refresh frames run back-to-back without requests.
module lcd_sequencer #(
  parameter int unsigned PWRUP_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES   = 100000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iWR,
  input  logic [4:0]        iWR_ADDR,
  input  logic [7:0]        iWR_DATA,
  input  logic              iRefresh,
  lcd_sequencer_if.master   lcd,
  output logic              oBusy,
  output logic              oInit_Done,
  output logic              oFrame_Done
);

  localparam int unsigned MAXC = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

`ifdef LCD_AUTO_REFRESH_EN
  localparam logic AUTO_REFRESH = 1'b1;
`else
  localparam logic AUTO_REFRESH = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      idx_q, idx_d;
  logic            pend_q, pend_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;
  logic            done_q;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic [7:0]      buf_q [32];
  logic [7:0]      buf_d [32];

  logic [7:0]      item_data;
  logic            item_rs;
  logic [4:0]      buf_addr;
  logic [7:0]      buf_char;
  logic            start_req;

  // Write-through bypass so a character written during its own LOAD is sent.
  assign buf_char  = (iWR && (iWR_ADDR == buf_addr)) ? iWR_DATA : buf_q[buf_addr];
  assign start_req = pend_q | iRefresh | AUTO_REFRESH;

  always_comb begin
    item_data = '0;
    item_rs   = 1'b0;
    buf_addr  = '0;
    if (!init_done_q) begin
      case (idx_q[1:0])
        2'd0:    item_data = 8'h38;
        2'd1:    item_data = 8'h0C;
        2'd2:    item_data = 8'h01;
        default: item_data = 8'h06;
      endcase
    end else if (idx_q == 6'd0) begin
      item_data = 8'h80;
    end else if (idx_q == 6'd17) begin
      item_data = 8'hC0;
    end else begin
      buf_addr  = (idx_q < 6'd17) ? 5'(idx_q - 6'd1) : 5'(idx_q - 6'd2);
      item_data = buf_char;
      item_rs   = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    data_d       = data_q;
    rs_d         = rs_q;
    buf_d        = buf_q;
    if (iWR) buf_d[iWR_ADDR] = iWR_DATA;

    // Requests before init completes fold into the mandatory post-init refresh.
    if (iRefresh && init_done_q && (state_q != S_IDLE)) pend_d = 1'b1;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CW'(PWRUP_CYCLES - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INIT: begin
        if (idx_q == 6'd4) begin
          init_done_d = 1'b1;
          idx_d       = '0;
        end
        state_d = S_LOAD;
      end
      S_IDLE: begin
        if (start_req) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d  = item_data;
        rs_d    = item_rs;
        state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (lcd.iDone && !done_q) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (!init_done_q) begin
            state_d = S_INIT;
          end else if (idx_d == 6'd34) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_PWRUP;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      rs_q         <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      done_q       <= lcd.iDone;
      data_q       <= data_d;
      rs_q         <= rs_d;
      buf_q        <= buf_d;
    end
  end

  assign lcd.oStart    = (state_q == S_START);
  assign lcd.oLCD_DATA = (state_q == S_LOAD) ? item_data : data_q;
  assign lcd.oLCD_RS   = (state_q == S_LOAD) ? item_rs : rs_q;
  assign lcd.oLCD_RW   = 1'b0;
  assign oBusy         = (state_q != S_IDLE) | pend_q | AUTO_REFRESH;
  assign oInit_Done    = init_done_q;
  assign oFrame_Done   = frame_done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: expected transfers queued at request time, checked on oStart.
module tb_lcd_sequencer;
  localparam int unsigned PW = 10;
  localparam int unsigned GP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       refresh = 1'b0;
  logic       busy, init_done, frame_done;

  lcd_sequencer_if lcd ();

  lcd_sequencer #(.PWRUP_CYCLES(PW), .GAP_CYCLES(GP)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iWR(wr), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .iRefresh(refresh), .lcd(lcd), .oBusy(busy), .oInit_Done(init_done),
    .oFrame_Done(frame_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb [$];
  logic [7:0] mbuf [32];
  int         start_cnt = 0;
  int         frame_cnt = 0;
  logic       busy_at_frame = 1'b0;
  int         cd = 0;
  logic       hold_mode = 1'b0;
  logic       pulse_low = 1'b0;
  logic [8:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask

  task automatic push_frame();
    sb.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, mbuf[i]});
    sb.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) sb.push_back({1'b1, mbuf[i]});
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; wr_addr = a; wr_data = d;
    mbuf[a] = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_reached", 32'(frame_cnt >= target), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("start_reached", 32'(start_cnt >= target), 32'd1);
  endtask

  task automatic check_pwrup_latency();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd.oStart && n < 40);
    if (n < int'(PW) || n > int'(PW) + 4) begin
      checks++; errors++;
      $display("FAIL pwrup_latency actual=%0d cycles required=%0d..%0d", n, PW, PW + 4);
    end else begin
      checks++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, 32'(lcd.oStart), 32'd0);
    chk({tag, "_data"},  32'(lcd.oLCD_DATA), 32'd0);
    chk({tag, "_rs"},    32'(lcd.oLCD_RS), 32'd0);
    chk({tag, "_rw"},    32'(lcd.oLCD_RW), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd1);
    chk({tag, "_init"},  32'(init_done), 32'd0);
    chk({tag, "_frame"}, 32'(frame_done), 32'd0);
  endtask

  // Monitor + enable-pulse generator model: iDone drops at oStart, rises 20 cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      cd = 0;
      lcd.iDone = 1'b1;
    end else begin
      if (lcd.oStart) begin
        start_cnt++;
        held = {lcd.oLCD_RS, lcd.oLCD_DATA};
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_transfer actual=rs%0d/0x%0h required=none", lcd.oLCD_RS, lcd.oLCD_DATA);
        end else begin
          chk("transfer", 32'({lcd.oLCD_RS, lcd.oLCD_DATA}), 32'(sb.pop_front()));
        end
        if (!hold_mode) begin
          cd = 20;
          lcd.iDone = 1'b0;
        end
      end else if (hold_mode) begin
        lcd.iDone = !pulse_low;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          chk("wait_stable", 32'({lcd.oLCD_RS, lcd.oLCD_DATA}), 32'(held));
          lcd.iDone = 1'b1;
        end
      end
      if (frame_done) begin
        frame_cnt++;
        busy_at_frame = busy;
      end
    end
  end

  initial begin
    int base;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

`ifdef LCD_AUTO_REFRESH_EN
    push_init();
    repeat (4) push_frame();
    rst_n = 1'b1;
    check_pwrup_latency();
    wait_frames(3, 4000);
    chk("auto_init_done", 32'(init_done), 32'd1);
    chk("auto_busy_at_frame", 32'(busy_at_frame), 32'd1);
`else
    // Power-up, init and mandatory refresh; a request during init must be absorbed.
    push_init();
    push_frame();
    rst_n = 1'b1;
    check_pwrup_latency();
    pulse_refresh();
    wait_frames(1, 3000);
    chk("init_done", 32'(init_done), 32'd1);
    chk("busy_at_frame1", 32'(busy_at_frame), 32'd0);
    repeat (60) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("sb_empty_1", 32'(sb.size()), 32'd0);

    // HELLO on line 1, X in the last cell of line 2.
    write_char(5'd0, "H"); write_char(5'd1, "E"); write_char(5'd2, "L");
    write_char(5'd3, "L"); write_char(5'd4, "O"); write_char(5'd31, "X");
    push_frame();
    pulse_refresh();
    wait_frames(2, 3000);
    chk("sb_empty_2", 32'(sb.size()), 32'd0);

    // Random buffer contents.
    for (int k = 0; k < 40; k++) write_char(5'($urandom_range(0, 31)), 8'($urandom));
    push_frame();
    pulse_refresh();
    wait_frames(3, 3000);
    chk("sb_empty_3", 32'(sb.size()), 32'd0);

    // Three requests during one refresh yield exactly one extra frame.
    push_frame();
    base = start_cnt;
    pulse_refresh();
    wait_starts(base + 3, 500);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      pulse_refresh();
    end
    push_frame();
    wait_frames(4, 3000);
    chk("busy_across_pending", 32'(busy_at_frame), 32'd1);
    wait_frames(5, 3000);
    repeat (80) @(negedge clk);
    chk("pending_idle_busy", 32'(busy), 32'd0);
    chk("sb_empty_4", 32'(sb.size()), 32'd0);

    // iDone held high: no rising edge, so WAIT holds until a 0->1 toggle.
    hold_mode = 1'b1;
    push_frame();
    base = start_cnt;
    pulse_refresh();
    wait_starts(base + 1, 200);
    base = start_cnt;
    repeat (50) @(negedge clk);
    chk("hold_data", 32'(lcd.oLCD_DATA), 32'h80);
    chk("hold_rs", 32'(lcd.oLCD_RS), 32'd0);
    chk("hold_no_start", 32'(start_cnt), 32'(base));
    chk("hold_busy", 32'(busy), 32'd1);
    pulse_low = 1'b1;
    repeat (3) @(negedge clk);
    pulse_low = 1'b0;
    repeat (2) @(negedge clk);
    hold_mode = 1'b0;
    wait_starts(base + 1, 30);
    wait_frames(6, 3000);
    chk("sb_empty_5", 32'(sb.size()), 32'd0);

    // Reset during the 10th transfer of a refresh.
    push_frame();
    base = start_cnt;
    pulse_refresh();
    wait_starts(base + 10, 1000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sb.delete();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    repeat (2) @(negedge clk);
    base = frame_cnt;
    push_init();
    push_frame();
    rst_n = 1'b1;
    check_pwrup_latency();
    wait_frames(base + 1, 3000);
    chk("reinit_done", 32'(init_done), 32'd1);
    repeat (20) @(negedge clk);
    chk("sb_empty_6", 32'(sb.size()), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter PWRUP_CYCLES, default 1000000: idle cycles after reset before the first command (20 ms at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 100000: idle cycles after each transfer completes (2 ms at 50 MHz, covers clear-display).
REQ-003 iCLK  in  1  single clock; all logic on posedge.
REQ-004 iRST_N  in  1  asynchronous, active-low reset.
REQ-005 iWR  in  1  write strobe for the character buffer.
REQ-006 iWR_ADDR  in  5  buffer address; 0-15 is line 1, 16-31 is line 2.
REQ-007 iWR_DATA  in  8  character code.
REQ-008 iRefresh  in  1  single-cycle request to redraw both lines.
REQ-009 iDone  in  1  completion flag from the enable-pulse generator; low while a transfer runs, high when finished.
REQ-010 oStart  out  1  transfer start pulse to the enable-pulse generator.
REQ-011 oLCD_DATA  out  8  command or character byte.
REQ-012 oLCD_RS  out  1  0 = command, 1 = data.
REQ-013 oLCD_RW  out  1  tied 0.
REQ-014 oBusy  out  1  high whenever the sequencer is not in IDLE.
REQ-015 oInit_Done  out  1  sticky high after the init command list completes.
REQ-016 oFrame_Done  out  1  one-cycle pulse when a refresh completes.

Function
REQ-017 Register a 32x8 character buffer; iWR=1 writes iWR_DATA at iWR_ADDR on that edge; writes are accepted in every state.
REQ-018 States: PWRUP, INIT, IDLE, LOAD, START, WAIT, GAP.
REQ-019 PWRUP: count PWRUP_CYCLES, then go to INIT.
REQ-020 Init list, in order, RS=0: 0x38, 0x0C, 0x01, 0x06. After the last item, set oInit_Done and run one refresh unconditionally.
REQ-021 Refresh list, 34 transfers: 0x80 (RS=0); buffer[0..15] (RS=1); 0xC0 (RS=0); buffer[16..31] (RS=1).
REQ-022 Per transfer:
  - LOAD drives oLCD_DATA/oLCD_RS for one cycle.
  - START asserts oStart for exactly one cycle, with data and RS unchanged.
  - WAIT holds data and RS until the first iDone 0->1 edge, detected by a registered copy of iDone.
  - GAP counts GAP_CYCLES, then advances the list index.
REQ-023 oLCD_DATA and oLCD_RS are stable from LOAD through the end of WAIT.
REQ-024 A buffer character is sampled in its own LOAD cycle; a write in that same cycle yields the new value.
REQ-025 After the last refresh item's GAP: pulse oFrame_Done for one cycle and return to IDLE.
REQ-026 iRefresh in IDLE starts a refresh on the next cycle.
REQ-027 iRefresh while oBusy=1 sets a pending flag; at most one refresh is pending.
REQ-028 A pending refresh starts on the cycle after the current refresh ends; that cycle is passed through IDLE, and oBusy stays 1 across it.
REQ-029 iRefresh during PWRUP or INIT is absorbed into the mandatory post-init refresh.
REQ-030 The list index is 6 bits and does not wrap; reaching index 34 terminates the refresh.
REQ-031 No timeout: if iDone never rises, the sequencer stays in WAIT until reset.

Reset
REQ-032 On iRST_N low, immediately:
  - state=PWRUP; counters, list index and pending flag = 0.
  - oStart=0, oLCD_DATA=0x00, oLCD_RS=0, oLCD_RW=0, oBusy=1, oInit_Done=0, oFrame_Done=0.
  - every buffer byte = 0x20 (space).
REQ-033 Reset asserted mid-transfer abandons the transfer; after release, the full PWRUP and INIT sequence repeats.

Configuration
REQ-034 Macro LCD_AUTO_REFRESH_EN.
  - Defined: IDLE treats the request as always pending; refreshes run back-to-back with no IDLE dwell, and iRefresh has no additional effect.
  - Undefined: refreshes run only per REQ-026..REQ-029.

Verification
REQ-035 PWRUP_CYCLES=10, GAP_CYCLES=4, iDone model rises 20 cycles after oStart, then release reset -> oStart first high after 10 cycles with oLCD_DATA=0x38, RS=0; init bytes appear as 38,0C,01,06 -> oInit_Done=1; 34 refresh transfers follow, all data bytes 0x20 -> oFrame_Done pulses once.
REQ-036 In IDLE, write "HELLO" at addresses 0-4 and 'X' at address 31, then pulse iRefresh -> transfer order 0x80, 'H','E','L','L','O', eleven 0x20, 0xC0, fifteen 0x20, 'X'; RS matches REQ-021.
REQ-037 Pulse iRefresh three times during a refresh -> exactly one extra refresh, then IDLE with oBusy=0.
REQ-038 Hold iDone high with no falling edge after oStart -> sequencer stays in WAIT with oLCD_DATA stable; then toggle iDone 0 then 1 -> proceeds to GAP.
REQ-039 Assert iRST_N low during the 10th refresh transfer -> outputs return to reset values asynchronously; after release, the first transfer is 0x38 after PWRUP_CYCLES.
REQ-040 With LCD_AUTO_REFRESH_EN defined and iRefresh held 0 -> oFrame_Done pulses continuously, once per 34-transfer frame.
